// File: rtl/l2_stream_fill.sv
// Fill side of one L2 stream: tags line requests with their slot index,
// writes out-of-order host responses into URAM and retires lines in order.
module l2_stream_fill #(
    parameter int addr_width       = 64,
    parameter int cache_line       = 128,
    parameter int cache_line_width = $clog2(cache_line),
    parameter int l2_ncl           = 256,
    parameter int l2_ncl_width     = $clog2(l2_ncl),
    parameter int l2_req_ncl_width = $clog2(l2_ncl + 1),
    parameter int data_width       = cache_line * 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_rst_v,
    output logic                    i_rst_r,
    input  logic [addr_width-1:0]   i_rst_ea_b,

    input  logic                    i_req_v,
    output logic                    i_req_r,
    input  logic [addr_width-1:0]   i_req_ea,

    output logic                    o_hreq_v,
    input  logic                    o_hreq_r,
    output logic [addr_width-1:0]   o_hreq_ea,
    output logic [l2_ncl_width-1:0] o_hreq_tag,

    input  logic                    i_hrsp_v,
    output logic                    i_hrsp_r,
    input  logic [l2_ncl_width-1:0] i_hrsp_tag,
    input  logic [data_width-1:0]   i_hrsp_data,

    output logic                    o_wr_v,
    output logic [l2_ncl_width-1:0] o_wr_addr,
    output logic [data_width-1:0]   o_wr_data,

    output logic                    o_rsp_v,
    input  logic                    o_rsp_r,

    output logic                    o_idle,
    output logic                    o_err
);

    localparam logic [l2_req_ncl_width-1:0] CntMax = l2_req_ncl_width'(l2_ncl);
    localparam logic [l2_req_ncl_width-1:0] CntOne = l2_req_ncl_width'(1);
    localparam logic [l2_ncl_width-1:0]     PtrOne = l2_ncl_width'(1);
    localparam int SlotHi = l2_ncl_width + cache_line_width;

    logic [l2_ncl_width-1:0]     wptr_q, wptr_d;
    logic [l2_ncl_width-1:0]     rptr_q, rptr_d;
    logic [l2_ncl-1:0]           pend_q, pend_d;
    logic [l2_ncl-1:0]           done_q, done_d;
    logic [l2_req_ncl_width-1:0] cnt_q, cnt_d;
    logic                        wr_v_q, wr_v_d;
    logic [l2_ncl_width-1:0]     wr_addr_q, wr_addr_d;
    logic [data_width-1:0]       wr_data_q, wr_data_d;
    logic                        err_q, err_d;

    logic                    full;
    logic                    req_acc;
    logic                    rsp_ok;
    logic                    rsp_bad;
    logic                    ret;
    logic                    rst_acc;
    logic [l2_ncl_width-1:0] rst_slot;

    // EA bits outside the slot index field do not affect placement.
    logic unused_ea;
    if (SlotHi < addr_width) begin : g_ea_hi
        assign unused_ea = ^{i_rst_ea_b[addr_width-1:SlotHi],
                             i_rst_ea_b[cache_line_width-1:0]};
    end else begin : g_ea_lo
        assign unused_ea = ^i_rst_ea_b[cache_line_width-1:0];
    end

    assign rst_slot = i_rst_ea_b[SlotHi-1:cache_line_width];

    assign full    = (cnt_q == CntMax);
    assign o_idle  = (cnt_q == '0);
    assign rst_acc = i_rst_v & o_idle;

    assign o_hreq_v   = i_req_v & ~full & ~i_rst_v;
    assign i_req_r    = o_hreq_r & ~full & ~i_rst_v;
    assign o_hreq_ea  = i_req_ea;
    assign o_hreq_tag = wptr_q;
    assign req_acc    = i_req_v & i_req_r;

    assign i_hrsp_r = 1'b1;
    assign rsp_ok   = i_hrsp_v & pend_q[i_hrsp_tag];
    assign rsp_bad  = i_hrsp_v & ~pend_q[i_hrsp_tag];

    // done is set only after the URAM write cycle, so a retire
    // never overtakes its own line write.
    assign o_rsp_v = done_q[rptr_q];
    assign ret     = o_rsp_v & o_rsp_r;

    assign o_wr_v    = wr_v_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_err     = err_q;
    assign i_rst_r   = rst_acc;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        pend_d    = pend_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        wr_v_d    = rsp_ok;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q | rsp_bad;

        if (rsp_ok) begin
            pend_d[i_hrsp_tag] = 1'b0;
            wr_addr_d          = i_hrsp_tag;
            wr_data_d          = i_hrsp_data;
        end

        if (wr_v_q) begin
            done_d[wr_addr_q] = 1'b1;
        end

        if (ret) begin
            done_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + PtrOne;
        end

        if (req_acc) begin
            pend_d[wptr_q] = 1'b1;
            wptr_d         = wptr_q + PtrOne;
        end

        case ({req_acc, ret})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase

        if (rst_acc) begin
            wptr_d = rst_slot;
            rptr_d = rst_slot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            pend_q    <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            wr_v_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            pend_q    <= pend_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            wr_v_q    <= wr_v_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_l2_stream_fill.sv
// Bench for l2_stream_fill with a 4-slot stream and a slot-state
// reference model driven by response arrival times.
module tb_l2_stream_fill;

    localparam int NCL = 4;
    localparam int AW  = 64;
    localparam int DW  = 1024;
    localparam int TW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_rst_v = 1'b0;
    logic          i_rst_r;
    logic [AW-1:0] i_rst_ea_b = '0;
    logic          i_req_v = 1'b0;
    logic          i_req_r;
    logic [AW-1:0] i_req_ea = '0;
    logic          o_hreq_v;
    logic          o_hreq_r = 1'b0;
    logic [AW-1:0] o_hreq_ea;
    logic [TW-1:0] o_hreq_tag;
    logic          i_hrsp_v = 1'b0;
    logic          i_hrsp_r;
    logic [TW-1:0] i_hrsp_tag = '0;
    logic [DW-1:0] i_hrsp_data = '0;
    logic          o_wr_v;
    logic [TW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_rsp_v;
    logic          o_rsp_r = 1'b0;
    logic          o_idle;
    logic          o_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_stream_fill #(.l2_ncl(NCL)) dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_ea_b(i_rst_ea_b),
        .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_ea(i_req_ea),
        .o_hreq_v(o_hreq_v), .o_hreq_r(o_hreq_r),
        .o_hreq_ea(o_hreq_ea), .o_hreq_tag(o_hreq_tag),
        .i_hrsp_v(i_hrsp_v), .i_hrsp_r(i_hrsp_r),
        .i_hrsp_tag(i_hrsp_tag), .i_hrsp_data(i_hrsp_data),
        .o_wr_v(o_wr_v), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
        .o_idle(o_idle), .o_err(o_err)
    );

    // Reference model: slot state 0=free 1=awaiting host 2=written,
    // plus the cycle from which a written line may be retired.
    int            st [NCL];
    longint        rdy [NCL];
    int            mw = 0;
    int            mr = 0;
    bit            merr = 0;
    bit            mwr_v = 0;
    int            mwr_addr = 0;
    logic [DW-1:0] mdata = '0;
    longint        cyc = 0;

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NCL; i++) if (st[i] != 0) n++;
        return n;
    endfunction

    function automatic bit e_req_r();
        return o_hreq_r && (m_cnt() < NCL) && !i_rst_v;
    endfunction

    function automatic bit e_hreq_v();
        return i_req_v && (m_cnt() < NCL) && !i_rst_v;
    endfunction

    function automatic bit e_rsp_v();
        return (st[mr] == 2) && (cyc >= rdy[mr]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCL; i++) st[i] = 0;
            mw = 0;
            mr = 0;
            merr = 0;
            mwr_v = 0;
        end else begin
            bit ra, rv, fa;
            int t;
            ra = i_req_v && e_req_r();
            rv = e_rsp_v() && o_rsp_r;
            fa = i_rst_v && (m_cnt() == 0);
            mwr_v = 0;
            if (i_hrsp_v) begin
                t = int'(i_hrsp_tag);
                if (st[t] == 1) begin
                    st[t] = 2;
                    rdy[t] = cyc + 2;
                    mwr_v = 1;
                    mwr_addr = t;
                    mdata = i_hrsp_data;
                end else begin
                    merr = 1;
                end
            end
            if (rv) begin
                st[mr] = 0;
                mr = (mr + 1) % NCL;
            end
            if (ra) begin
                st[mw] = 1;
                mw = (mw + 1) % NCL;
            end
            if (fa) begin
                mw = int'((i_rst_ea_b >> 7) % NCL);
                mr = mw;
            end
            cyc++;
        end
    end

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int q[$];
        int n;
        i_req_v = 0;
        i_rst_v = 0;
        o_rsp_r = 1;
        for (n = 0; n < 100 && m_cnt() != 0; n++) begin
            q.delete();
            for (int i = 0; i < NCL; i++) if (st[i] == 1) q.push_back(i);
            if (q.size() > 0) begin
                i_hrsp_v = 1;
                i_hrsp_tag = TW'(q[$urandom_range(q.size() - 1)]);
                i_hrsp_data = rnd_line();
            end else begin
                i_hrsp_v = 0;
            end
            tick();
        end
        i_hrsp_v = 0;
        checks++;
        if (m_cnt() != 0 || o_idle !== 1'b1) begin
            errors++;
            $display("FAIL drain: open=%0d idle=%b want 0 and 1", m_cnt(), o_idle);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_hreq_v, o_wr_v, o_rsp_v, o_err, o_idle, i_hrsp_r} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_outputs: hv/wv/rv/err/idle/hr=%b want 000011",
                     {o_hreq_v, o_wr_v, o_rsp_v, o_err, o_idle, i_hrsp_r});
        end
        reset = 0;
        tick();
    endtask

    task automatic test_in_order();
        logic [AW-1:0] ea;
        logic [DW-1:0] sent [3];
        o_hreq_r = 1;
        for (int i = 0; i < 3; i++) begin
            ea = 64'h1000 + 64'(i) * 64'h80;
            i_req_v = 1;
            i_req_ea = ea;
            @(negedge clk);
            checks++;
            if ({o_hreq_v, i_req_r} !== 2'b11 || o_hreq_tag !== TW'(i) || o_hreq_ea !== ea) begin
                errors++;
                $display("FAIL in_order_req%0d: v/r=%b%b tag=%0d ea=%h want 11 tag=%0d ea=%h",
                         i, o_hreq_v, i_req_r, o_hreq_tag, o_hreq_ea, i, ea);
            end
            tick();
        end
        i_req_v = 0;
        o_rsp_r = 1;
        for (int k = 0; k < 7; k++) begin
            bit ew, er;
            ew = (k >= 1) && (k <= 3);
            er = (k >= 2) && (k <= 4);
            if (k < 3) begin
                sent[k] = rnd_line();
                i_hrsp_v = 1;
                i_hrsp_tag = TW'(k);
                i_hrsp_data = sent[k];
            end else begin
                i_hrsp_v = 0;
            end
            @(negedge clk);
            checks++;
            if (o_wr_v !== ew || o_rsp_v !== er) begin
                errors++;
                $display("FAIL in_order_k%0d: wr_v=%b rsp_v=%b want %b %b", k, o_wr_v, o_rsp_v, ew, er);
            end
            if (ew) begin
                checks++;
                if (o_wr_addr !== TW'(k - 1) || o_wr_data !== sent[k-1]) begin
                    errors++;
                    $display("FAIL in_order_wr%0d: addr=%0d want %0d (or data differs)",
                             k, o_wr_addr, k - 1);
                end
            end
            tick();
        end
        checks++;
        if (o_idle !== 1'b1) begin
            errors++;
            $display("FAIL in_order_idle: got %b want 1", o_idle);
        end
    endtask

    task automatic test_out_of_order();
        int t [3];
        int ord [3];
        o_hreq_r = 1;
        o_rsp_r = 1;
        for (int i = 0; i < 3; i++) begin
            t[i] = (mw + i) % NCL;
        end
        ord = '{t[2], t[0], t[1]};
        for (int i = 0; i < 3; i++) begin
            i_req_v = 1;
            i_req_ea = 64'h4000 + 64'(i) * 64'h80;
            @(negedge clk);
            checks++;
            if (o_hreq_v !== 1'b1 || o_hreq_tag !== TW'(t[i])) begin
                errors++;
                $display("FAIL ooo_req%0d: v=%b tag=%0d want 1 tag=%0d", i, o_hreq_v, o_hreq_tag, t[i]);
            end
            tick();
        end
        i_req_v = 0;
        for (int k = 0; k < 8; k++) begin
            bit ew, er;
            ew = (k >= 1) && (k <= 3);
            er = (k >= 3) && (k <= 5);
            if (k < 3) begin
                i_hrsp_v = 1;
                i_hrsp_tag = TW'(ord[k]);
                i_hrsp_data = rnd_line();
            end else begin
                i_hrsp_v = 0;
            end
            @(negedge clk);
            checks++;
            if (o_wr_v !== ew || o_rsp_v !== er || (ew && o_wr_addr !== TW'(ord[k-1]))) begin
                errors++;
                $display("FAIL ooo_k%0d: wr_v=%b addr=%0d rsp_v=%b want wr_v=%b rsp_v=%b",
                         k, o_wr_v, o_wr_addr, o_rsp_v, ew, er);
            end
            tick();
        end
    endtask

    task automatic test_full_wrap();
        int t [NCL];
        o_hreq_r = 1;
        o_rsp_r = 1;
        for (int i = 0; i < NCL; i++) begin
            t[i] = mw;
            i_req_v = 1;
            i_req_ea = 64'h8000 + 64'(i) * 64'h80;
            tick();
        end
        i_req_ea = 64'h9000;
        for (int k = 0; k < 4; k++) begin
            i_hrsp_v = (k == 0);
            i_hrsp_tag = TW'(t[0]);
            i_hrsp_data = rnd_line();
            @(negedge clk);
            checks++;
            if (k < 3 && {i_req_r, o_hreq_v} !== 2'b00) begin
                errors++;
                $display("FAIL full_k%0d: req_r/hreq_v=%b%b want 00", k, i_req_r, o_hreq_v);
            end
            if (k == 2 && o_rsp_v !== 1'b1) begin
                errors++;
                $display("FAIL full_retire: rsp_v=%b want 1", o_rsp_v);
            end
            if (k == 3 && ({i_req_r, o_hreq_v} !== 2'b11 || o_hreq_tag !== TW'(t[0]))) begin
                errors++;
                $display("FAIL full_wrap: req_r/hreq_v=%b%b tag=%0d want 11 tag=%0d",
                         i_req_r, o_hreq_v, o_hreq_tag, t[0]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_func_reset();
        int a;
        a = mw;
        o_hreq_r = 1;
        o_rsp_r = 1;
        i_req_v = 1;
        repeat (2) tick();
        i_rst_v = 1;
        i_rst_ea_b = 64'h2180;
        for (int k = 0; k < 5; k++) begin
            bit er;
            er = (k == 4);
            i_hrsp_v = (k < 2);
            i_hrsp_tag = TW'((a + k) % NCL);
            i_hrsp_data = rnd_line();
            @(negedge clk);
            checks++;
            if (i_rst_r !== er || o_hreq_v !== 1'b0 || i_req_r !== 1'b0) begin
                errors++;
                $display("FAIL freset_k%0d: rst_r=%b hreq_v=%b req_r=%b want %b 0 0",
                         k, i_rst_r, o_hreq_v, i_req_r, er);
            end
            tick();
        end
        i_rst_v = 0;
        i_hrsp_v = 0;
        @(negedge clk);
        checks++;
        if (o_hreq_v !== 1'b1 || o_hreq_tag !== TW'(3)) begin
            errors++;
            $display("FAIL freset_tag: hreq_v=%b tag=%0d want 1 tag=3", o_hreq_v, o_hreq_tag);
        end
        tick();
        drain();
    endtask

    task automatic test_err();
        i_req_v = 0;
        o_rsp_r = 1;
        for (int k = 0; k < 5; k++) begin
            i_hrsp_v = (k == 0);
            i_hrsp_tag = TW'(3);
            i_hrsp_data = rnd_line();
            @(negedge clk);
            checks++;
            if (o_err !== (k > 0) || o_wr_v !== 1'b0 || o_rsp_v !== 1'b0) begin
                errors++;
                $display("FAIL err_k%0d: err=%b wr_v=%b rsp_v=%b want %b 0 0",
                         k, o_err, o_wr_v, o_rsp_v, k > 0);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int old [2];
        int late;
        o_hreq_r = 1;
        o_rsp_r = 0;
        for (int i = 0; i < 2; i++) begin
            old[i] = mw;
            i_req_v = 1;
            tick();
        end
        i_req_v = 0;
        #1;
        reset = 1;
        #1;
        checks++;
        if ({o_hreq_v, o_wr_v, o_rsp_v, o_err, o_idle, i_hrsp_r} !== 6'b000011) begin
            errors++;
            $display("FAIL areset_outputs: hv/wv/rv/err/idle/hr=%b want 000011",
                     {o_hreq_v, o_wr_v, o_rsp_v, o_err, o_idle, i_hrsp_r});
        end
        @(negedge clk);
        reset = 0;
        tick();
        i_req_v = 1;
        @(negedge clk);
        checks++;
        if (o_hreq_v !== 1'b1 || o_hreq_tag !== TW'(0)) begin
            errors++;
            $display("FAIL areset_tag: hreq_v=%b tag=%0d want 1 tag=0", o_hreq_v, o_hreq_tag);
        end
        tick();
        i_req_v = 0;
        late = (old[0] != 0) ? old[0] : old[1];
        i_hrsp_v = 1;
        i_hrsp_tag = TW'(late);
        i_hrsp_data = rnd_line();
        tick();
        i_hrsp_v = 0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_wr_v !== 1'b0) begin
            errors++;
            $display("FAIL areset_late: err=%b wr_v=%b want 1 0", o_err, o_wr_v);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        int q[$];
        logic [10:0] obs, expv;
        for (int c = 0; c < 400; c++) begin
            i_req_v = 1'($urandom);
            i_req_ea = {$urandom, $urandom} & ~64'h7f;
            o_hreq_r = ($urandom % 4) != 0;
            o_rsp_r = ($urandom % 3) != 0;
            i_rst_v = ($urandom % 24) == 0;
            i_rst_ea_b = {$urandom, $urandom};
            q.delete();
            for (int i = 0; i < NCL; i++) if (st[i] == 1) q.push_back(i);
            i_hrsp_v = (q.size() > 0) && ($urandom % 2 == 1);
            i_hrsp_tag = (q.size() > 0) ? TW'(q[$urandom_range(q.size() - 1)]) : '0;
            i_hrsp_data = rnd_line();
            @(negedge clk);
            obs = {o_hreq_v, i_req_r, o_hreq_tag, o_wr_v, o_rsp_v, o_idle, o_err, i_rst_r,
                   1'(o_hreq_ea == i_req_ea)};
            expv = {e_hreq_v(), e_req_r(), TW'(mw), mwr_v, e_rsp_v(), m_cnt() == 0, merr,
                    i_rst_v && (m_cnt() == 0), 1'b1};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random_c%0d: outputs=%b want %b", c, obs, expv);
            end
            if (mwr_v) begin
                checks++;
                if (o_wr_addr !== TW'(mwr_addr) || o_wr_data !== mdata) begin
                    errors++;
                    $display("FAIL random_wr_c%0d: addr=%0d want %0d (or data differs)",
                             c, o_wr_addr, mwr_addr);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_full_wrap();
        test_func_reset();
        test_err();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
